vga_sync_rx: RTL and testbench
==============================

# vga_sync_rx

Recovers pixel timing from an incoming VGA sync stream. It is the receive-side counterpart of the 640x480 sync generator. It samples `hsync`/`vsync` on each pixel tick, locks free-running horizontal/vertical counters to the sync edges, and regenerates `pixel_x`, `pixel_y` and `video_on` for downstream capture or overlay logic. It also reports lock status and sync errors so loopback tests and frame grabbers can qualify the recovered coordinates.

## Interface
Parameters:
- `HD`, 640: horizontal display pixels
- `HTOTAL`, 800: pixels per line
- `HS_START`, 656: recovered `pixel_x` assigned to the first tick where `hsync` is sampled high
- `VD`, 480: display lines
- `VTOTAL`, 525: lines per frame
- `VS_START`, 513: recovered `pixel_y` assigned to the first line whose `hsync` edge samples `vsync` high
- `LOCK_LINES`, 4: consecutive aligned `hsync` edges required for lock

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `p_tick`  in  1  pixel enable; all sampling and counting occur only on `clk` edges with `p_tick`=1
- `hsync`  in  1  horizontal sync, active high
- `vsync`  in  1  vertical sync, active high
- `pixel_x`  out  10  recovered column
- `pixel_y`  out  10  recovered row
- `video_on`  out  1  `locked && pixel_x<HD && pixel_y<VD`
- `locked`  out  1  high in LOCKED state
- `sync_err`  out  1  one-`clk` pulse on an alignment violation
- `line_len`  out  10  last measured hsync-to-hsync period in ticks (stats build only)
- `err_cnt`  out  8  saturating count of `sync_err` pulses (stats build only)

## Operation
- **Edge detection.** `hs_prev`/`vs_prev` are registered on ticks. The hsync edge is `hsync & ~hs_prev` at a tick. The vsync edge is evaluated only at hsync-edge ticks: `vsync` is high there and `vs_prev_line` is low.
- **Counters.** Counters are 10-bit. `h_cnt` increments per tick and wraps `HTOTAL-1`→0. `v_cnt` increments on the h wrap and wraps `VTOTAL-1`→0.
- **Expected hsync position.** At an hsync-edge tick, the expected value is `h_cnt_next == HS_START`. A mismatch means `h_cnt` is loaded with `HS_START`.
- **Expected vsync position.** At a vsync edge, the expected value is `v_cnt == VS_START`. A mismatch means `v_cnt` is loaded with `VS_START`.
- **States.**
  - SEARCH: counters hold at 0 and `locked`=0. The first hsync edge loads `h_cnt`=`HS_START`, clears `good`, and moves to HLOCK.
  - HLOCK: an aligned hsync edge increments `good`, which saturates at `LOCK_LINES`. A misaligned edge reloads, clears `good`, and pulses `sync_err`. A vsync edge is checked the same way; a misaligned vsync edge clears `good` and pulses `sync_err`. The state moves to LOCKED when `good>=LOCK_LINES` and at least one aligned vsync edge has been seen since entering HLOCK.
  - LOCKED: any misaligned h or v edge reloads, pulses `sync_err`, clears `good`, and moves to HLOCK.
- **Timeout.** An 11-bit tick counter clears on every hsync edge. When it reaches `2*HTOTAL` ticks with no hsync edge, the block moves to SEARCH from any state. Timeout does not pulse `sync_err`.
- **Simultaneous events.** The h and v checks on the same tick both apply, and only one `sync_err` pulse is issued. The timeout tick coinciding with an hsync edge counts as an edge, so there is no timeout.
- **Ticks with `p_tick`=0.** All state holds.

## Timing
- **Reset values.** All outputs are 0, the state is SEARCH, and `hs_prev`/`vs_prev` are 0.
- **Coordinate latency.** `pixel_x`/`pixel_y` are the registered counters. A value loaded at an edge tick is visible on the next `clk`.
- **`sync_err`.** Asserted the `clk` after the offending tick, for exactly one `clk`.
- **`locked`.** Rises the `clk` after the qualifying edge and falls the `clk` after a violation or timeout.
- **`video_on`.** Combinational from the registered signals.
- **Reset mid-frame.** The block returns to SEARCH immediately and needs at least `LOCK_LINES` lines plus one vsync edge to relock.

## Configuration
- `VGA_SYNC_RX_STATS_EN` defined: `line_len` is captured at each hsync edge from a period counter, and `err_cnt` saturates at 255.
- `VGA_SYNC_RX_STATS_EN` undefined: `line_len` and `err_cnt` are tied to 0 and no stats registers are built. All other behaviour is identical.

## Structure
- **Shared package `vga_timing_pkg`.** Holds the 640x480 timing constants (`HD`, `HF`, `HB`, `HR`, `VD`, `VF`, `VB`, `VR`, with totals derived from them) and the state enum `{SEARCH, HLOCK, LOCKED}`. The generator and this block share these.
- **Sub-module `sync_edge_det`.** Tick-qualified rising-edge detector, instantiated twice (hsync; vsync gated by the hsync edge).

## Test plan
- **Clean lock.** Drive the generator output with `p_tick` every 2nd clk. Required response:
  - `locked`=1 after the 4th aligned hsync plus the vsync edge.
  - Afterwards, `pixel_x`/`pixel_y` match the generator's with constant offset 0 and `sync_err` never pulses.
- **Horizontal slip.** Drop 3 ticks of `hsync` position in one line. Required response:
  - One `sync_err` pulse, `locked` falls, and `h_cnt` is reloaded to 656.
  - Relock after 4 lines plus the next vsync.
- **Vertical slip.** Inject a vsync edge on line 500. Required response: `sync_err` pulses, `pixel_y` reads 513 on the next line's edge, and the block goes to HLOCK.
- **Loss of sync.** Hold `hsync`=0 for 1600 ticks. Required response: state goes to SEARCH, `locked`=0, `pixel_x`=`pixel_y`=0, and no `sync_err` pulse.
- **Async reset.** Assert `reset` mid-line while LOCKED. Required response: all outputs are 0 immediately (no clk edge needed), and the block relocks on the following frame.
- **Stats build.** With `VGA_SYNC_RX_STATS_EN` defined, `line_len`=800 on clean lines, and `err_cnt` reads 255 after 300 forced errors.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module   : vga_timing_pkg
// Desc     : 640x480 VGA timing constants and sync-recovery state encoding,
//            shared by the sync generator and the sync receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int HD       = 640;
    localparam int HF       = 16;
    localparam int HB       = 48;
    localparam int HR       = 96;
    localparam int HTOTAL   = HD + HF + HB + HR;

    localparam int VD       = 480;
    localparam int VF       = 10;
    localparam int VB       = 33;
    localparam int VR       = 2;
    localparam int VTOTAL   = VD + VF + VB + VR;

    // Receiver phase references: column of the first hsync pixel and the
    // row the receiver assigns to the first line that sees vsync high.
    localparam int HS_START = HD + HF;
    localparam int VS_START = VD + VB;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        HLOCK  = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    function automatic logic [9:0] wrap_inc(input logic [9:0] value,
                                            input logic [9:0] last);
        return (value == last) ? 10'd0 : value + 10'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
// Module   : sync_edge_det
// Desc     : Tick-qualified rising-edge detector; the history register only
//            advances on qualifying ticks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic din,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else if (tick) begin
            r_prev <= din;
        end
    end

    assign rise = tick & din & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/vga_sync_rx.sv
// ============================================================================
// Module   : vga_sync_rx
// Desc     : Recovers pixel_x/pixel_y/video_on from an incoming VGA sync
//            stream, with lock tracking and sync error reporting.
//            Optional line-length / error statistics: VGA_SYNC_RX_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_rx
    import vga_timing_pkg::*;
#(
    parameter int HD         = vga_timing_pkg::HD,
    parameter int HTOTAL     = vga_timing_pkg::HTOTAL,
    parameter int HS_START   = vga_timing_pkg::HS_START,
    parameter int VD         = vga_timing_pkg::VD,
    parameter int VTOTAL     = vga_timing_pkg::VTOTAL,
    parameter int VS_START   = vga_timing_pkg::VS_START,
    parameter int LOCK_LINES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       locked,
    output logic       sync_err,
    output logic [9:0] line_len,
    output logic [7:0] err_cnt
);

    localparam int              GW         = $clog2(LOCK_LINES + 1);
    localparam logic [9:0]      C_H_LAST   = 10'(HTOTAL - 1);
    localparam logic [9:0]      C_V_LAST   = 10'(VTOTAL - 1);
    localparam logic [9:0]      C_HS_START = 10'(HS_START);
    localparam logic [9:0]      C_VS_START = 10'(VS_START);
    localparam logic [9:0]      C_HD       = 10'(HD);
    localparam logic [9:0]      C_VD       = 10'(VD);
    localparam logic [10:0]     C_TO_LIMIT = 11'(2 * HTOTAL);
    localparam logic [GW-1:0]   C_LOCK     = GW'(LOCK_LINES);

    sync_state_t   r_state;
    logic [9:0]    r_h_cnt;
    logic [9:0]    r_v_cnt;
    logic [GW-1:0] r_good;
    logic          r_v_seen;
    logic [10:0]   r_to_cnt;
    logic          r_locked;
    logic          r_sync_err;

    logic          w_h_edge;
    logic          w_v_edge;

    sync_edge_det u_hs_edge (
        .clk   (clk),
        .reset (reset),
        .tick  (p_tick),
        .din   (hsync),
        .rise  (w_h_edge)
    );

    // vsync is only looked at once per line, on the hsync edge tick.
    sync_edge_det u_vs_edge (
        .clk   (clk),
        .reset (reset),
        .tick  (w_h_edge),
        .din   (vsync),
        .rise  (w_v_edge)
    );

    logic [9:0]    w_h_next;
    logic [9:0]    w_v_next;
    logic [9:0]    w_h_load;
    logic [9:0]    w_v_load;
    logic          w_h_mis;
    logic          w_v_mis;
    logic          w_v_ok;
    logic          w_err;
    logic [GW-1:0] w_good_nx;
    logic          w_v_seen_nx;
    logic [10:0]   w_to_next;
    logic          w_timeout;

    assign w_h_next    = wrap_inc(r_h_cnt, C_H_LAST);
    assign w_v_next    = (r_h_cnt == C_H_LAST) ? wrap_inc(r_v_cnt, C_V_LAST) : r_v_cnt;
    assign w_h_mis     = w_h_edge && (w_h_next != C_HS_START);
    assign w_v_mis     = w_v_edge && (r_v_cnt != C_VS_START);
    assign w_v_ok      = w_v_edge && (r_v_cnt == C_VS_START);
    assign w_err       = w_h_mis || w_v_mis;
    assign w_h_load    = w_h_edge ? C_HS_START : w_h_next;
    assign w_v_load    = w_v_mis ? C_VS_START : w_v_next;
    assign w_good_nx   = w_err ? '0 :
                         (w_h_edge && (r_good < C_LOCK)) ? r_good + 1'b1 : r_good;
    assign w_v_seen_nx = r_v_seen || w_v_ok;
    assign w_to_next   = r_to_cnt + 11'd1;
    // An edge on the limit tick wins over the timeout.
    assign w_timeout   = p_tick && !w_h_edge && (w_to_next == C_TO_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= SEARCH;
            r_h_cnt    <= '0;
            r_v_cnt    <= '0;
            r_good     <= '0;
            r_v_seen   <= 1'b0;
            r_to_cnt   <= '0;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= 1'b0;
            if (p_tick) begin
                r_to_cnt <= (w_h_edge || w_timeout) ? 11'd0 : w_to_next;
                if (w_timeout) begin
                    r_state  <= SEARCH;
                    r_h_cnt  <= '0;
                    r_v_cnt  <= '0;
                    r_good   <= '0;
                    r_v_seen <= 1'b0;
                    r_locked <= 1'b0;
                end else begin
                    case (r_state)
                        SEARCH: begin
                            if (w_h_edge) begin
                                r_h_cnt  <= C_HS_START;
                                r_good   <= '0;
                                r_v_seen <= 1'b0;
                                r_state  <= HLOCK;
                            end
                        end
                        HLOCK: begin
                            r_h_cnt    <= w_h_load;
                            r_v_cnt    <= w_v_load;
                            r_good     <= w_good_nx;
                            r_v_seen   <= w_v_seen_nx;
                            r_sync_err <= w_err;
                            if ((w_good_nx >= C_LOCK) && w_v_seen_nx) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end
                        LOCKED: begin
                            r_h_cnt    <= w_h_load;
                            r_v_cnt    <= w_v_load;
                            r_good     <= w_good_nx;
                            r_sync_err <= w_err;
                            if (w_err) begin
                                r_state  <= HLOCK;
                                r_locked <= 1'b0;
                                r_v_seen <= 1'b0;
                            end
                        end
                        default: begin
                            r_state  <= SEARCH;
                            r_locked <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign pixel_x  = r_h_cnt;
    assign pixel_y  = r_v_cnt;
    assign locked   = r_locked;
    assign sync_err = r_sync_err;
    assign video_on = r_locked && (r_h_cnt < C_HD) && (r_v_cnt < C_VD);

`ifdef VGA_SYNC_RX_STATS_EN
    logic [9:0] r_per_cnt;
    logic [9:0] r_line_len;
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_per_cnt  <= '0;
            r_line_len <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (p_tick) begin
                if (w_h_edge) begin
                    r_line_len <= (r_per_cnt == 10'h3FF) ? 10'h3FF : r_per_cnt + 10'd1;
                    r_per_cnt  <= '0;
                end else if (r_per_cnt != 10'h3FF) begin
                    r_per_cnt  <= r_per_cnt + 10'd1;
                end
            end
            if (r_sync_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign line_len = r_line_len;
    assign err_cnt  = r_err_cnt;
`else
    assign line_len = '0;
    assign err_cnt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_rx.sv
// ============================================================================
// Module   : tb_vga_sync_rx
// Desc     : Directed self-checking bench for vga_sync_rx on a reduced
//            24x12 timing; pixel tick every second clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_rx;

    localparam int T_HD     = 16;
    localparam int T_HTOTAL = 24;
    localparam int T_HS     = 18;
    localparam int T_HR     = 3;
    localparam int T_VD     = 8;
    localparam int T_VTOTAL = 12;
    localparam int T_VS     = 9;
    localparam int T_VR     = 2;
    localparam int T_LOCK   = 4;
    localparam int FRAME    = T_HTOTAL * T_VTOTAL;

    logic       clk;
    logic       reset;
    logic       p_tick;
    logic       hsync;
    logic       vsync;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       locked;
    logic       sync_err;
    logic [9:0] line_len;
    logic [7:0] err_cnt;

    int n_asserts  = 0;
    int n_fail     = 0;
    int err_pulses = 0;
    int gen_x      = 0;
    int gen_y      = 0;

    vga_sync_rx #(
        .HD         (T_HD),
        .HTOTAL     (T_HTOTAL),
        .HS_START   (T_HS),
        .VD         (T_VD),
        .VTOTAL     (T_VTOTAL),
        .VS_START   (T_VS),
        .LOCK_LINES (T_LOCK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .p_tick   (p_tick),
        .hsync    (hsync),
        .vsync    (vsync),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .video_on (video_on),
        .locked   (locked),
        .sync_err (sync_err),
        .line_len (line_len),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int expected);
        n_asserts++;
        if (act != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, expected, $time);
        end
    endtask

    // One pixel tick: inputs driven at a falling edge, consumed at the
    // following rising edge, outputs sampled at the next falling edge.
    task automatic pix(input logic hs, input logic vs);
        @(negedge clk);
        p_tick = 1'b1;
        hsync  = hs;
        vsync  = vs;
        @(negedge clk);
        p_tick = 1'b0;
        if (sync_err) err_pulses++;
    endtask

    // Generator drives the sync levels belonging to the position it moves
    // to, so a locked receiver reports the same coordinates.
    task automatic gen_tick(input logic force_vs);
        int nx;
        int ny;
        nx = gen_x + 1;
        ny = gen_y;
        if (nx == T_HTOTAL) begin
            nx = 0;
            ny = (gen_y == T_VTOTAL - 1) ? 0 : gen_y + 1;
        end
        pix((nx >= T_HS) && (nx < T_HS + T_HR),
            force_vs || ((ny >= T_VS) && (ny < T_VS + T_VR)));
        gen_x = nx;
        gen_y = ny;
    endtask

    task automatic run_to(input int x, input int y);
        int n;
        n = 0;
        while (!((gen_x == x) && (gen_y == y)) && (n < 2 * FRAME)) begin
            gen_tick(1'b0);
            n++;
        end
        if (n >= 2 * FRAME) check_eq("run_to_reached", gen_x * 1000 + gen_y, x * 1000 + y);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pos_mis;
        int vid_mis;
        int n;

        reset  = 1'b1;
        p_tick = 1'b0;
        hsync  = 1'b0;
        vsync  = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_pixel_x",  pixel_x,  0);
        check_eq("rst_pixel_y",  pixel_y,  0);
        check_eq("rst_video_on", video_on, 0);
        check_eq("rst_locked",   locked,   0);
        check_eq("rst_sync_err", sync_err, 0);
        check_eq("rst_line_len", line_len, 0);
        check_eq("rst_err_cnt",  err_cnt,  0);
        reset = 1'b0;

        // Clean lock: 4 aligned lines, then the first aligned vsync edge.
        run_to(17, 9);
        check_eq("lock_pre_vs",     locked, 0);
        check_eq("lock_no_err",     err_pulses, 0);
        gen_tick(1'b0);
        check_eq("lock_at_vs",      locked, 1);
        check_eq("lock_pixel_x",    pixel_x, 18);
        check_eq("lock_pixel_y",    pixel_y, 9);

        pos_mis = 0;
        vid_mis = 0;
        repeat (FRAME) begin
            gen_tick(1'b0);
            if ((pixel_x != gen_x) || (pixel_y != gen_y)) pos_mis++;
            if (video_on != ((gen_x < T_HD) && (gen_y < T_VD))) vid_mis++;
        end
        check_eq("frame_pos_mismatches",   pos_mis, 0);
        check_eq("frame_video_mismatches", vid_mis, 0);
        check_eq("frame_sync_err_pulses",  err_pulses, 0);
        check_eq("frame_locked",           locked, 1);
`ifdef VGA_SYNC_RX_STATS_EN
        check_eq("stats_line_len", line_len, T_HTOTAL);
`endif

        // Horizontal slip: generator skips 3 ticks in line 0.
        run_to(5, 0);
        gen_x = 8;
        err_pulses = 0;
        run_to(17, 0);
        check_eq("hslip_pre_pixel_x", pixel_x, 14);
        gen_tick(1'b0);
        check_eq("hslip_sync_err",  sync_err, 1);
        check_eq("hslip_locked",    locked, 0);
        check_eq("hslip_reload_x",  pixel_x, 18);
        gen_tick(1'b0);
        check_eq("hslip_err_width", sync_err, 0);
        run_to(18, 4);
        check_eq("hslip_good_no_vs", locked, 0);
        run_to(17, 9);
        check_eq("hslip_pre_relock", locked, 0);
        gen_tick(1'b0);
        check_eq("hslip_relock",     locked, 1);
        check_eq("hslip_err_pulses", err_pulses, 1);

        // Vertical slip: spurious vsync edge on line 6.
        run_to(17, 6);
        err_pulses = 0;
        gen_tick(1'b1);
        check_eq("vslip_sync_err",  sync_err, 1);
        check_eq("vslip_reload_y",  pixel_y, T_VS);
        check_eq("vslip_locked",    locked, 0);
        run_to(18, 9);
        check_eq("vslip_true_vs_err", sync_err, 1);
        check_eq("vslip_true_vs_y",   pixel_y, T_VS);
        check_eq("vslip_err_pulses",  err_pulses, 2);
        run_to(17, 9);
        check_eq("vslip_pre_relock", locked, 0);
        gen_tick(1'b0);
        check_eq("vslip_relock",     locked, 1);

        // Loss of sync: timeout exactly 2*HTOTAL ticks after the last edge.
        err_pulses = 0;
        repeat (2 * T_HTOTAL - 1) pix(1'b0, 1'b0);
        check_eq("los_pre_locked",  locked, 1);
        check_eq("los_pre_pixel_x", pixel_x, 17);
        check_eq("los_pre_pixel_y", pixel_y, 11);
        pix(1'b0, 1'b0);
        check_eq("los_locked",     locked, 0);
        check_eq("los_pixel_x",    pixel_x, 0);
        check_eq("los_pixel_y",    pixel_y, 0);
        check_eq("los_err_pulses", err_pulses, 0);

        // hsync rising without a tick must not register as history.
        @(negedge clk);
        hsync = 1'b1;
        repeat (4) @(negedge clk);
        pix(1'b1, 1'b0);
        check_eq("notick_edge_kept", pixel_x, T_HS);

        // Forced errors: an hsync edge every second tick.
        err_pulses = 0;
        repeat (300) begin
            pix(1'b0, 1'b0);
            pix(1'b1, 1'b0);
        end
        check_eq("forced_err_pulses", err_pulses, 300);
        check_eq("forced_locked",     locked, 0);
`ifdef VGA_SYNC_RX_STATS_EN
        check_eq("stats_err_cnt_sat", err_cnt, 255);
`else
        check_eq("nostats_err_cnt",  err_cnt, 0);
        check_eq("nostats_line_len", line_len, 0);
`endif

        repeat (2 * T_HTOTAL) pix(1'b0, 1'b0);
        check_eq("to_from_hlock_x",      pixel_x, 0);
        check_eq("to_from_hlock_locked", locked, 0);

        gen_x = 0;
        gen_y = 0;
        err_pulses = 0;
        run_to(18, 9);
        check_eq("relock2_locked", locked, 1);
        check_eq("relock2_errs",   err_pulses, 0);

        // Asynchronous reset mid-line while locked.
        run_to(10, 3);
        check_eq("prerst_video_on", video_on, 1);
        check_eq("prerst_pixel_x",  pixel_x, 10);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_pixel_x",  pixel_x, 0);
        check_eq("arst_pixel_y",  pixel_y, 0);
        check_eq("arst_locked",   locked, 0);
        check_eq("arst_video_on", video_on, 0);
        check_eq("arst_err_cnt",  err_cnt, 0);
        @(negedge clk);
        reset = 1'b0;

        n = 0;
        while (!locked && (n < 3 * FRAME)) begin
            gen_tick(1'b0);
            n++;
        end
        check_eq("arst_relock",   locked, 1);
        check_eq("arst_relock_x", pixel_x, gen_x);
        check_eq("arst_relock_y", pixel_y, gen_y);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
